// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, defaults and helpers
package uart_pkg;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic int umax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser for an asynchronous single-bit input
module uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; define UART_RX_PARITY_EN for a parity bit
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int STOP_TICKS = 16
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rx_done_tick,
   output logic                 frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int SW = $clog2(umax(OVERSAMPLE, STOP_TICKS));
   localparam int NW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state_q, state_d;
   logic [SW-1:0]        s_q, s_d;
   logic [NW-1:0]        n_q, n_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
`endif

   uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif
      case (state_q)
         // Start edge is taken on any clock so the mid-bit point is tick-accurate.
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  if (!rx_s) begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (s_q == S_BIT) begin
                  s_d     = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (s_tick) begin
               if (s_q == S_BIT) begin
                  s_d     = '0;
                  par_d   = rx_s;
                  state_d = ST_STOP;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP) begin
                  state_d = ST_IDLE;
                  dout_d  = shift_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = (^shift_q) ^ par_q ^ PARITY_ODD;
`endif
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (8N1, 16x oversampling)
module tb_uart_rx;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLK  = 16 * TICK_DIV;

   logic       clk;
   logic       reset;
   logic       s_tick;
   logic       rx;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int         n_total;
   int         n_pass;
   int         done_cnt;
   int         wide_cnt;
   int         base;
   logic       prev_done;
   logic [7:0] cap[$];

   uart_rx dut (
      .clk          (clk),
      .reset        (reset),
      .s_tick       (s_tick),
      .rx           (rx),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err   (parity_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   end

   initial begin
      done_cnt  = 0;
      wide_cnt  = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rx_done_tick === 1'b1) begin
            done_cnt++;
            cap.push_back(dout);
            if (prev_done === 1'b1) wide_cnt++;
         end
         prev_done = rx_done_tick;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_body(input logic [7:0] d);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
   endtask

   task automatic send_stop(input logic stop_b);
      if (stop_b) begin
         drive_bit(1'b1);
      end else begin
         rx = 1'b0;
         repeat (BIT_CLK * 3 / 4) @(negedge clk);
         rx = 1'b1;
         repeat (BIT_CLK / 4) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      send_body(d);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      send_stop(stop_b);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_parity_frame(input logic [7:0] d, input logic par_b);
      send_body(d);
      drive_bit(par_b);
      send_stop(1'b1);
   endtask
`endif

   task automatic idle(input int bits);
      rx = 1'b1;
      repeat (bits * BIT_CLK) @(negedge clk);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset   = 1'b0;
      rx      = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_dout", dout, 8'h00);
      check("rst_done", rx_done_tick, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
`ifdef UART_RX_PARITY_EN
      check("rst_perr", parity_err, 1'b0);
`endif
      reset = 1'b1;
      idle(2);

      base = done_cnt;
      send_frame(8'h55, 1'b1);
      idle(1);
      check("t1_done_cnt", done_cnt - base, 1);
      check("t1_dout", dout, 8'h55);
      check("t1_ferr", frame_err, 1'b0);

      base = done_cnt;
      rx = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      idle(2);
      check("t2_no_done", done_cnt - base, 0);
      check("t2_dout_hold", dout, 8'h55);

      base = done_cnt;
      send_frame(8'hA3, 1'b0);
      idle(2);
      check("t3a_done_cnt", done_cnt - base, 1);
      check("t3a_dout", dout, 8'hA3);
      check("t3a_ferr", frame_err, 1'b1);
      base = done_cnt;
      send_frame(8'h01, 1'b1);
      idle(1);
      check("t3b_done_cnt", done_cnt - base, 1);
      check("t3b_dout", dout, 8'h01);
      check("t3b_ferr", frame_err, 1'b0);

      base = done_cnt;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx = 1'b0;
      repeat (BIT_CLK / 2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("t4_rst_dout", dout, 8'h00);
      check("t4_rst_done", rx_done_tick, 1'b0);
      check("t4_rst_ferr", frame_err, 1'b0);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      idle(2);
      check("t4_no_done", done_cnt - base, 0);
      base = done_cnt;
      send_frame(8'h0F, 1'b1);
      idle(1);
      check("t4_done_cnt", done_cnt - base, 1);
      check("t4_dout", dout, 8'h0F);

      base = done_cnt;
      cap.delete();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h81, 1'b1);
      idle(1);
      check("t5_done_cnt", done_cnt - base, 3);
      check("t5_d0", (cap.size() >= 3) ? 32'(cap[0]) : 32'hDEAD, 8'h00);
      check("t5_d1", (cap.size() >= 3) ? 32'(cap[1]) : 32'hDEAD, 8'hFF);
      check("t5_d2", (cap.size() >= 3) ? 32'(cap[2]) : 32'hDEAD, 8'h81);

`ifdef UART_RX_PARITY_EN
      base = done_cnt;
      send_parity_frame(8'h07, 1'b0);
      idle(1);
      check("t6a_done_cnt", done_cnt - base, 1);
      check("t6a_dout", dout, 8'h07);
      check("t6a_perr", parity_err, 1'b1);
      send_parity_frame(8'h07, 1'b1);
      idle(1);
      check("t6b_perr", parity_err, 1'b0);
`endif

      check("done_width", wide_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
